// File: rtl/byte_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : byte_bus_master
// Purpose  : Serial-command bus initiator. Decodes read/write command bytes,
//            issues single-word rd/wr accesses and streams response bytes.
//            Optional macro BYTE_BUS_MASTER_AUTOINC_EN adds write-next (0x03)
//            and read-next (0x04) opcodes using addr+4.
// Revision : 1.0 - initial release
// ============================================================================
module byte_bus_master #(
    parameter int unsigned RD_WAIT  = 0,
    parameter logic [7:0]  UNK_CODE = 8'hEE,
    parameter logic [7:0]  ACK_CODE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4,
        RESP  = 3'd5
    } state_t;

    localparam logic [3:0] c_rd_wait = RD_WAIT[3:0];
    localparam logic [7:0] c_op_wr   = 8'h01;
    localparam logic [7:0] c_op_rd   = 8'h02;
`ifdef BYTE_BUS_MASTER_AUTOINC_EN
    localparam logic [7:0] c_op_wrn  = 8'h03;
    localparam logic [7:0] c_op_rdn  = 8'h04;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_op_wr;
    logic [1:0]  r_cnt;
    logic [3:0]  r_wait;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_resp;
    logic [1:0]  r_resp_left;
`ifdef BYTE_BUS_MASTER_AUTOINC_EN
    logic        r_inc;
`endif

    logic w_rx_fire;
    logic w_tx_fire;

    assign rx_ready  = (r_state == IDLE) || (r_state == ADDR) || (r_state == DATA);
    assign w_rx_fire = rx_valid && rx_ready;
    assign tx_valid  = (r_state == RESP);
    assign w_tx_fire = tx_valid && tx_ready;
    assign tx_data   = r_resp[31:24];
    assign rd        = (r_state == READ);
    assign wr        = (r_state == WRITE);
    assign busy      = (r_state != IDLE);
    assign addr      = r_addr;
    assign wdata     = r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_rx_fire) begin
                    case (rx_data)
                        c_op_wr, c_op_rd: w_state_nxt = ADDR;
`ifdef BYTE_BUS_MASTER_AUTOINC_EN
                        c_op_wrn:         w_state_nxt = DATA;
                        c_op_rdn:         w_state_nxt = READ;
`endif
                        default:          w_state_nxt = RESP;
                    endcase
                end
            end
            ADDR: begin
                if (w_rx_fire && (r_cnt == 2'd3)) begin
                    w_state_nxt = r_op_wr ? DATA : READ;
                end
            end
            DATA: begin
                if (w_rx_fire && (r_cnt == 2'd3)) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: w_state_nxt = RESP;
            READ: begin
                if (r_wait == c_rd_wait) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (w_tx_fire && (r_resp_left == 2'd0)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: address/data shift registers, rd wait counter, response shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_wr     <= 1'b0;
            r_cnt       <= 2'd0;
            r_wait      <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_resp      <= 32'd0;
            r_resp_left <= 2'd0;
`ifdef BYTE_BUS_MASTER_AUTOINC_EN
            r_inc       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rx_fire) begin
                        r_cnt   <= 2'd0;
                        r_wait  <= 4'd0;
                        r_op_wr <= (rx_data == c_op_wr);
`ifdef BYTE_BUS_MASTER_AUTOINC_EN
                        r_inc   <= (rx_data == c_op_wrn);
                        if (rx_data == c_op_rdn) begin
                            r_addr <= r_addr + 32'd4;
                        end
`endif
                        r_resp      <= {UNK_CODE, 24'h0};
                        r_resp_left <= 2'd0;
                    end
                end
                ADDR: begin
                    if (w_rx_fire) begin
                        r_addr <= {r_addr[23:0], rx_data};
                        r_cnt  <= r_cnt + 2'd1;
                    end
                end
                DATA: begin
                    if (w_rx_fire) begin
                        r_wdata <= {r_wdata[23:0], rx_data};
                        r_cnt   <= r_cnt + 2'd1;
`ifdef BYTE_BUS_MASTER_AUTOINC_EN
                        if ((r_cnt == 2'd3) && r_inc) begin
                            r_addr <= r_addr + 32'd4;
                        end
`endif
                    end
                end
                WRITE: begin
                    r_resp      <= {ACK_CODE, 24'h0};
                    r_resp_left <= 2'd0;
                end
                READ: begin
                    if (r_wait == c_rd_wait) begin
                        r_resp      <= rdata;
                        r_resp_left <= 2'd3;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                RESP: begin
                    if (w_tx_fire) begin
                        r_resp      <= {r_resp[23:0], 8'h00};
                        r_resp_left <= r_resp_left - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
